dmem_arbiter: RTL and testbench

- Shares the single-port data memory (word-addressed RAM, 4-bit byte-lane write mask "amp", combinational read, write on posedge) between two masters: m0 = CPU load/store unit, m1 = loader/debug DMA port.
- Sits between the masters and dmem. Provides:
  - per-cycle round-robin arbitration;
  - optional locked bursts, bounded by a counter;
  - registered read-data return;
  - rejection of illegal byte-lane masks.

---
 rtl/dmem_arbiter_pkg.sv | 29 ++
 rtl/dmem_arbiter_rr_arb2.sv | 87 ++++++++
 rtl/dmem_arbiter.sv | 99 +++++++++
 tb/tb_dmem_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: legal byte-lane masks,
// arbiter state encoding and a mask-legality helper.
// Latency: n/a (constants and pure functions only). Backpressure: n/a.
package dmem_arbiter_pkg;

    // Byte-lane masks dmem accepts: full word, two halfwords, four bytes.
    localparam logic [3:0] AMP_W  = 4'b1111;
    localparam logic [3:0] AMP_H0 = 4'b0011;
    localparam logic [3:0] AMP_H1 = 4'b1100;
    localparam logic [3:0] AMP_B0 = 4'b0001;
    localparam logic [3:0] AMP_B1 = 4'b0010;
    localparam logic [3:0] AMP_B2 = 4'b0100;
    localparam logic [3:0] AMP_B3 = 4'b1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    function automatic logic amp_is_legal(input logic [3:0] amp);
        case (amp)
            AMP_W, AMP_H0, AMP_H1,
            AMP_B0, AMP_B1, AMP_B2, AMP_B3: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with optional locked bursts capped at BURST_MAX grants.
// Latency: grant is combinational in the request cycle; state/last/count update on posedge.
// Backpressure: an ungranted master simply keeps req high; a locked owner blocks the other.
// Ports: clk, reset (sync, active-high); i_req/i_lock per master;
//        o_gnt one-hot grant vector; o_state current arbiter state.
module rr_arb2
    import dmem_arbiter_pkg::*;
#(
    parameter int BURST_MAX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic [1:0] i_lock,
    output logic [1:0] o_gnt,
    output arb_state_t o_state
);

    localparam int CW = $clog2(BURST_MAX + 1);

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic            r_last;       // index of the most recently granted master
    logic            w_last_nxt;
    logic [CW-1:0]   r_cnt;        // granted cycles in the current locked burst
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_cnt_inc;
    logic [1:0]      w_gnt;
    logic            w_own;        // owning master while locked
    logic            w_pick;       // master chosen in IDLE

    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_gnt       = 2'b00;
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_own       = (r_state == LOCK1);
        w_pick      = 1'b0;

        // Nothing is granted while reset is held, so no write can slip out.
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    if (i_req != 2'b00) begin
                        // On a tie the master that did not win last time goes.
                        w_pick        = (i_req == 2'b11) ? ~r_last : i_req[1];
                        w_gnt[w_pick] = 1'b1;
                        w_last_nxt    = w_pick;
                        // A burst cap of one means the first grant is already the last.
                        if (i_lock[w_pick] && (BURST_MAX > 1)) begin
                            w_state_nxt = w_pick ? LOCK1 : LOCK0;
                            w_cnt_nxt   = CW'(1);
                        end
                    end
                end
                LOCK0, LOCK1: begin
                    w_gnt[w_own] = i_req[w_own];
                    if (i_req[w_own]) begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                    if (!i_req[w_own] || !i_lock[w_own] || (w_cnt_inc == CW'(BURST_MAX))) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign o_gnt   = w_gnt;
    assign o_state = r_state;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port dmem between the CPU LSU (m0) and the loader/debug DMA (m1).
// Latency: grant and memory access in the request cycle; load data/rvalid/err one cycle later.
// Backpressure: ungranted requests are held by the master until m*_gnt is seen.
// Ports: clk, reset (sync, active-high); per-master req/lock/we/amp/addr/wd in,
//        gnt/rvalid/rdata/err out; mem_we/amp/a/wd to dmem, mem_rd from dmem.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW        = 9,
    parameter int DW        = 32,
    parameter int BURST_MAX = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m1_req,
    input  logic          m0_lock,
    input  logic          m1_lock,
    input  logic          m0_we,
    input  logic          m1_we,
    input  logic [3:0]    m0_amp,
    input  logic [3:0]    m1_amp,
    input  logic [AW-1:0] m0_addr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m0_wd,
    input  logic [DW-1:0] m1_wd,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m0_err,
    output logic          m1_err,
    output logic          mem_we,
    output logic [3:0]    mem_amp,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    logic [1:0] w_gnt;
    arb_state_t w_state;
    logic       w_sel1;
    logic       w_we;
    logic       w_legal;

    rr_arb2 #(.BURST_MAX(BURST_MAX)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_req   ({m1_req, m0_req}),
        .i_lock  ({m1_lock, m0_lock}),
        .o_gnt   (w_gnt),
        .o_state (w_state)
    );

    // m1 drives the bus when granted, and also while it owns a lock so the
    // address stays steady across a bubble; otherwise m0 fields are presented.
    assign w_sel1  = w_gnt[1] | (w_state == LOCK1);
    assign mem_a   = w_sel1 ? m1_addr : m0_addr;
    assign mem_amp = w_sel1 ? m1_amp  : m0_amp;
    assign mem_wd  = w_sel1 ? m1_wd   : m0_wd;
    assign w_we    = w_sel1 ? m1_we   : m0_we;
    assign w_legal = amp_is_legal(mem_amp);
    assign mem_we  = (|w_gnt) & w_we & w_legal;

    assign m0_gnt = w_gnt[0];
    assign m1_gnt = w_gnt[1];

    logic r_m0_rvalid, r_m1_rvalid, r_m0_err, r_m1_err;
    logic [DW-1:0] r_m0_rdata, r_m1_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_err    <= 1'b0;
            r_m1_err    <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
        end else begin
            r_m0_rvalid <= w_gnt[0] & ~m0_we;
            r_m1_rvalid <= w_gnt[1] & ~m1_we;
            // When a master is granted the mux selects it, so w_legal is its own mask check.
            r_m0_err    <= w_gnt[0] & m0_we & ~w_legal;
            r_m1_err    <= w_gnt[1] & m1_we & ~w_legal;
            if (w_gnt[0] & ~m0_we) r_m0_rdata <= mem_rd;
            if (w_gnt[1] & ~m1_we) r_m1_rdata <= mem_rd;
        end
    end

    assign m0_rvalid = r_m0_rvalid;
    assign m1_rvalid = r_m1_rvalid;
    assign m0_err    = r_m0_err;
    assign m1_err    = r_m1_err;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural dmem and per-master load scoreboards.
// Latency: drives at posedge+1, checks combinational outputs at posedge+2, registered ones at posedge+1.
// Backpressure: the stimulus holds req until the grant is observed.
module tb_dmem_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m1_req, m0_lock, m1_lock, m0_we, m1_we;
    logic [3:0]    m0_amp, m1_amp;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wd, m1_wd;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_we;
    logic [3:0]    mem_amp;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd, mem_rd;

    logic          preload_en;
    logic [31:0]   ram [0:127];
    logic [31:0]   exp0[$];
    logic [31:0]   exp1[$];
    int            n_assert = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req), .m0_lock(m0_lock), .m1_lock(m1_lock),
        .m0_we(m0_we), .m1_we(m1_we), .m0_amp(m0_amp), .m1_amp(m1_amp),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wd(m0_wd), .m1_wd(m1_wd),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_err(m0_err), .m1_err(m1_err),
        .mem_we(mem_we), .mem_amp(mem_amp), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Behavioural dmem: combinational read, byte-lane write on posedge.
    assign mem_rd = ram[mem_a[8:2]];
    always @(posedge clk) begin
        if (preload_en) begin
            for (int i = 0; i < 128; i++) ram[i] <= 32'h0;
            ram[4]  <= 32'hDEADBEEF;
            ram[12] <= 32'hCAFEF00D;
            ram[16] <= 32'h12345678;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_amp[b]) ram[mem_a[8:2]][b*8 +: 8] <= mem_wd[b*8 +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every rvalid pops the oldest expected load result of that master.
    always @(negedge clk) begin
        if (m0_rvalid === 1'b1) begin
            if (exp0.size() == 0) chk("m0 unexpected rvalid", 32'd1, 32'd0);
            else                  chk("m0 rdata sb", m0_rdata, exp0.pop_front());
        end
        if (m1_rvalid === 1'b1) begin
            if (exp1.size() == 0) chk("m1 unexpected rvalid", 32'd1, 32'd0);
            else                  chk("m1 rdata sb", m1_rdata, exp1.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m1_req = 0; m0_lock = 0; m1_lock = 0; m0_we = 0; m1_we = 0;
        m0_amp = 4'hF; m1_amp = 4'hF; m0_addr = '0; m1_addr = '0; m0_wd = '0; m1_wd = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n1_gnt;
        int m0_first;
        int both;

        // Reset with a store request present: no grant, no write.
        idle_inputs();
        reset = 1; preload_en = 1;
        m0_req = 1; m0_we = 1; m0_addr = 9'h020; m0_wd = 32'hFFFFFFFF;
        tick(); #1;
        chk("reset m0_gnt", {31'd0, m0_gnt}, 32'd0);
        chk("reset mem_we", {31'd0, mem_we}, 32'd0);
        tick();
        chk("reset rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        chk("reset err", {30'd0, m1_err, m0_err}, 32'd0);
        chk("reset rdata", m0_rdata | m1_rdata, 32'd0);
        idle_inputs(); reset = 0; preload_en = 0;

        // m0 load of RAM[4].
        m0_req = 1; m0_addr = 9'h010; exp0.push_back(32'hDEADBEEF);
        #1;
        chk("load m0_gnt", {31'd0, m0_gnt}, 32'd1);
        chk("load mem_a", {23'd0, mem_a}, 32'h010);
        tick(); idle_inputs();
        chk("load m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
        chk("load m0_rdata", m0_rdata, 32'hDEADBEEF);
        tick();
        chk("load rvalid pulse", {31'd0, m0_rvalid}, 32'd0);
        chk("load rdata hold", m0_rdata, 32'hDEADBEEF);

        // Both masters store straight out of reset: m0 first, then m1.
        reset = 1; tick(); reset = 0;
        m0_req = 1; m0_we = 1; m0_addr = 9'h020; m0_wd = 32'h11111111;
        m1_req = 1; m1_we = 1; m1_addr = 9'h024; m1_wd = 32'h22222222;
        #1;
        chk("tie gnt", {30'd0, m1_gnt, m0_gnt}, 32'b01);
        chk("tie mem_we", {31'd0, mem_we}, 32'd1);
        chk("tie mem_wd", mem_wd, 32'h11111111);
        tick(); m0_req = 0; m0_we = 0; #1;
        chk("second gnt", {30'd0, m1_gnt, m0_gnt}, 32'b10);
        chk("second mem_a", {23'd0, mem_a}, 32'h024);
        tick(); idle_inputs();
        chk("ram word 8", ram[8], 32'h11111111);
        chk("ram word 9", ram[9], 32'h22222222);
        m1_req = 1; m1_addr = 9'h020; exp1.push_back(32'h11111111);
        tick(); idle_inputs();

        // m1 locked burst against a continuously requesting m0.
        n1_gnt = 0; m0_first = -1; both = 0;
        m1_req = 1; m1_lock = 1; m1_addr = 9'h010;
        m0_addr = 9'h020;
        for (int c = 0; c < 9; c++) begin
            m0_req = (c >= 1);
            #1;
            if (m0_gnt && m1_gnt) both++;
            if (m1_gnt) begin n1_gnt++; exp1.push_back(32'hDEADBEEF); end
            if (m0_gnt && m0_first < 0) begin m0_first = c; exp0.push_back(32'h11111111); end
            tick();
        end
        idle_inputs();
        chk("burst m1 grants", n1_gnt, 32'd8);
        chk("burst m0 first cycle", m0_first, 32'd8);
        chk("burst never both", both, 32'd0);

        // Illegal mask store: no write, one-cycle err.
        m0_req = 1; m0_we = 1; m0_amp = 4'b0110; m0_addr = 9'h030; m0_wd = 32'hFFFFFFFF;
        #1;
        chk("illegal gnt", {31'd0, m0_gnt}, 32'd1);
        chk("illegal mem_we", {31'd0, mem_we}, 32'd0);
        tick(); idle_inputs();
        chk("illegal err", {31'd0, m0_err}, 32'd1);
        tick();
        chk("illegal err pulse", {31'd0, m0_err}, 32'd0);
        chk("illegal ram", ram[12], 32'hCAFEF00D);

        // Byte store into lane 2.
        m0_req = 1; m0_we = 1; m0_amp = 4'b0100; m0_addr = 9'h040; m0_wd = 32'h00AB0000;
        #1;
        chk("sb mem_we", {31'd0, mem_we}, 32'd1);
        chk("sb mem_amp", {28'd0, mem_amp}, 32'h4);
        tick(); idle_inputs();
        chk("sb ram", ram[16], 32'h12AB5678);
        m0_req = 1; m0_addr = 9'h040; exp0.push_back(32'h12AB5678);
        tick(); idle_inputs();

        // Reset during an m0 locked burst with a store pending.
        m0_req = 1; m0_lock = 1; m0_addr = 9'h010; exp0.push_back(32'hDEADBEEF);
        #1;
        chk("lock0 gnt", {31'd0, m0_gnt}, 32'd1);
        tick();
        reset = 1; m0_we = 1; m0_addr = 9'h050; m0_wd = 32'h55555555;
        #1;
        chk("midreset gnt", {31'd0, m0_gnt}, 32'd0);
        chk("midreset mem_we", {31'd0, mem_we}, 32'd0);
        tick(); reset = 0; idle_inputs();
        m0_req = 1; m0_addr = 9'h040; m1_req = 1; m1_addr = 9'h010;
        exp0.push_back(32'h12AB5678);
        #1;
        chk("postreset rvalid/err", {30'd0, m0_rvalid, m0_err}, 32'd0);
        chk("postreset ram", ram[20], 32'd0);
        chk("postreset tie gnt", {30'd0, m1_gnt, m0_gnt}, 32'b01);
        tick(); m0_req = 0; exp1.push_back(32'hDEADBEEF);
        #1;
        chk("postreset m1 gnt", {30'd0, m1_gnt, m0_gnt}, 32'b10);
        tick(); idle_inputs();

        // Locked owner drops req while the other waits.
        m1_req = 1; m1_lock = 1; m1_addr = 9'h010; exp1.push_back(32'hDEADBEEF);
        #1;
        chk("drop lock gnt", {30'd0, m1_gnt, m0_gnt}, 32'b10);
        tick(); m0_req = 1; m0_addr = 9'h020; exp1.push_back(32'hDEADBEEF);
        #1;
        chk("drop held gnt", {30'd0, m1_gnt, m0_gnt}, 32'b10);
        tick(); m1_req = 0;
        #1;
        chk("drop bubble gnt", {30'd0, m1_gnt, m0_gnt}, 32'b00);
        tick(); exp0.push_back(32'h11111111);
        #1;
        chk("drop handover gnt", {30'd0, m1_gnt, m0_gnt}, 32'b01);
        tick(); idle_inputs();

        tick(); tick(); tick();
        chk("sb m0 drained", exp0.size(), 32'd0);
        chk("sb m1 drained", exp1.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
